// File: rtl/prog_counter.sv
// Fetch-stage program counter: sequences IDLE/RUN/HALT, applies jumps, branches,
// stalls and halts, and keeps a saturating count of retired instructions.
module prog_counter #(
  parameter int PC_W     = 12,
  parameter int END_ADDR = 4095,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  Start_addr,
  input  logic             Stall,
  input  logic             Jump_en,
  input  logic             Branch_en,
  input  logic             Cond,
  input  logic [PC_W-1:0]  Target,
  input  logic             Halt,
  output logic [PC_W-1:0]  Prog_ctr,
  output logic             Valid,
  output logic             Done,
  output logic [CNT_W-1:0] Instr_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  END_PC  = PC_W'(END_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_seq;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             valid_q;
  logic             done_q;
  logic             take_jump;
  logic             end_reached;

  // Jump_en wins over Branch_en, so Cond only matters for a lone branch.
  assign take_jump   = Jump_en | (Branch_en & Cond);
  assign end_reached = (pc_q == END_PC);
  assign pc_seq      = pc_q + PC_W'(1);
  assign cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (Start) begin
      state_q <= RUN;
      pc_q    <= Start_addr;
      cnt_q   <= '0;
      valid_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          // A stalled cycle retires nothing; the decoder re-presents its controls.
          if (!Stall) begin
            cnt_q <= cnt_d;
            if (Halt || (!take_jump && end_reached)) begin
              state_q <= HALT;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else if (take_jump) begin
              pc_q <= Target;
            end else begin
              pc_q <= pc_seq;
            end
          end
        end
        IDLE, HALT: ;
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Prog_ctr  = pc_q;
  assign Valid     = valid_q;
  assign Done      = done_q;
  assign Instr_cnt = cnt_q;

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: three instances (default, END_ADDR=20, CNT_W=4) share
// control inputs; directed scenarios plus a randomized run against a reference model.
module tb_prog_counter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [11:0] Start_addr = '0;
  logic        Stall = 1'b0;
  logic        Jump_en = 1'b0;
  logic        Branch_en = 1'b0;
  logic        Cond = 1'b0;
  logic [11:0] Target = '0;
  logic        Halt = 1'b0;

  // The short-program instance sees addresses folded into its legal range.
  logic [11:0] sa_b;
  logic [11:0] tgt_b;
  assign sa_b  = Start_addr % 12'd21;
  assign tgt_b = Target % 12'd21;

  logic [11:0] pc_a, pc_b, pc_c;
  logic        vld_a, vld_b, vld_c;
  logic        done_a, done_b, done_c;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  int total = 0;
  int bad   = 0;

  // Reference model, one entry per instance.
  int m_pc   [3];
  int m_cnt  [3];
  bit m_run  [3];
  bit m_halt [3];

  always #5 Clk = ~Clk;

  prog_counter u_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Start_addr(Start_addr), .Stall(Stall),
    .Jump_en(Jump_en), .Branch_en(Branch_en), .Cond(Cond), .Target(Target), .Halt(Halt),
    .Prog_ctr(pc_a), .Valid(vld_a), .Done(done_a), .Instr_cnt(cnt_a)
  );

  prog_counter #(.END_ADDR(20)) u_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Start_addr(sa_b), .Stall(Stall),
    .Jump_en(Jump_en), .Branch_en(Branch_en), .Cond(Cond), .Target(tgt_b), .Halt(Halt),
    .Prog_ctr(pc_b), .Valid(vld_b), .Done(done_b), .Instr_cnt(cnt_b)
  );

  prog_counter #(.CNT_W(4)) u_c (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Start_addr(Start_addr), .Stall(Stall),
    .Jump_en(Jump_en), .Branch_en(Branch_en), .Cond(Cond), .Target(Target), .Halt(Halt),
    .Prog_ctr(pc_c), .Valid(vld_c), .Done(done_c), .Instr_cnt(cnt_c)
  );

  // The decoder must never hand the short-program instance a target past its end.
  always @(posedge Clk) begin
    if (Reset && (Jump_en || (Branch_en && Cond)))
      assert (int'(tgt_b) <= 20) else $error("target beyond END_ADDR");
  end

  function automatic int pc_of(int i);
    return (i == 0) ? int'(pc_a) : (i == 1) ? int'(pc_b) : int'(pc_c);
  endfunction
  function automatic int cnt_of(int i);
    return (i == 0) ? int'(cnt_a) : (i == 1) ? int'(cnt_b) : int'(cnt_c);
  endfunction
  function automatic bit vld_of(int i);
    return (i == 0) ? vld_a : (i == 1) ? vld_b : vld_c;
  endfunction
  function automatic bit done_of(int i);
    return (i == 0) ? done_a : (i == 1) ? done_b : done_c;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pc[i] = 0; m_cnt[i] = 0; m_run[i] = 0; m_halt[i] = 0;
    end
  endfunction

  function automatic void model_step();
    int last, cmax, tgt, sa;
    if (!Reset) return;
    for (int i = 0; i < 3; i++) begin
      last = (i == 1) ? 20 : 4095;
      cmax = (i == 2) ? 15 : 65535;
      tgt  = (i == 1) ? int'(Target) % 21 : int'(Target);
      sa   = (i == 1) ? int'(Start_addr) % 21 : int'(Start_addr);
      if (Start) begin
        m_pc[i] = sa; m_cnt[i] = 0; m_run[i] = 1; m_halt[i] = 0;
      end else if (m_run[i] && !Stall) begin
        if (m_cnt[i] < cmax) m_cnt[i]++;
        if (Halt) begin
          m_run[i] = 0; m_halt[i] = 1;
        end else if (Jump_en || (Branch_en && Cond)) begin
          m_pc[i] = tgt;
        end else if (m_pc[i] == last) begin
          m_run[i] = 0; m_halt[i] = 1;
        end else begin
          m_pc[i] = (m_pc[i] + 1) % 4096;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic ctl_clear();
    Start = 0; Stall = 0; Jump_en = 0; Branch_en = 0; Cond = 0; Halt = 0;
  endtask

  task automatic test_reset();
    ctl_clear();
    #1 Reset = 1'b0;
    model_reset();
    tick(); tick();
    Reset = 1'b1;
    tick();
    total++;
    if (pc_a !== 12'd0 || vld_a !== 1'b0 || done_a !== 1'b0 || cnt_a !== 16'd0) begin
      bad++;
      $display("FAIL reset_state got pc=%0d v=%b d=%b cnt=%0d want 0/0/0/0", pc_a, vld_a, done_a, cnt_a);
    end
    Start = 1; Start_addr = 12'd30;
    tick();
    Start = 0;
    repeat (7) tick();
    total++;
    if (pc_a !== 12'd37 || vld_a !== 1'b1) begin
      bad++; $display("FAIL pre_reset_pc got %0d want 37", pc_a);
    end
    #2 Reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (pc_a !== 12'd0 || vld_a !== 1'b0 || done_a !== 1'b0 || cnt_a !== 16'd0) begin
      bad++;
      $display("FAIL async_reset got pc=%0d v=%b d=%b cnt=%0d want 0/0/0/0", pc_a, vld_a, done_a, cnt_a);
    end
    Start = 1; Jump_en = 1; Target = 12'd99;
    tick(); tick();
    total++;
    if (pc_a !== 12'd0 || vld_a !== 1'b0) begin
      bad++; $display("FAIL reset_hold got pc=%0d v=%b want 0/0", pc_a, vld_a);
    end
    ctl_clear();
    Reset = 1'b1;
    Jump_en = 1; Target = 12'd44; Stall = 1;
    tick(); tick();
    total++;
    if (pc_a !== 12'd0 || vld_a !== 1'b0 || cnt_a !== 16'd0) begin
      bad++; $display("FAIL idle_ignores got pc=%0d v=%b cnt=%0d want 0/0/0", pc_a, vld_a, cnt_a);
    end
    ctl_clear();
  endtask

  task automatic test_sequential();
    Start = 1; Start_addr = 12'd5;
    tick();
    Start = 0;
    total++;
    if (pc_a !== 12'd5 || vld_a !== 1'b1 || cnt_a !== 16'd0) begin
      bad++; $display("FAIL seq_start got pc=%0d v=%b cnt=%0d want 5/1/0", pc_a, vld_a, cnt_a);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      total++;
      if (int'(pc_a) != 5 + k) begin
        bad++; $display("FAIL seq_step%0d got pc=%0d want %0d", k, pc_a, 5 + k);
      end
    end
    total++;
    if (cnt_a !== 16'd3 || vld_a !== 1'b1) begin
      bad++; $display("FAIL seq_cnt got cnt=%0d v=%b want 3/1", cnt_a, vld_a);
    end
  endtask

  task automatic test_jump_branch();
    Start = 1; Start_addr = 12'd10;
    tick();
    Start = 0; Jump_en = 1; Target = 12'd88;
    tick();
    total++;
    if (pc_a !== 12'd88) begin bad++; $display("FAIL jump got pc=%0d want 88", pc_a); end
    Jump_en = 0; Branch_en = 1; Cond = 0; Target = 12'd147;
    tick();
    total++;
    if (pc_a !== 12'd89) begin bad++; $display("FAIL branch_nt got pc=%0d want 89", pc_a); end
    Cond = 1;
    tick();
    total++;
    if (pc_a !== 12'd147 || cnt_a !== 16'd3) begin
      bad++; $display("FAIL branch_t got pc=%0d cnt=%0d want 147/3", pc_a, cnt_a);
    end
    Branch_en = 0; Cond = 0; Jump_en = 1; Target = 12'd147;
    repeat (3) tick();
    total++;
    if (pc_a !== 12'd147 || cnt_a !== 16'd6 || vld_a !== 1'b1) begin
      bad++; $display("FAIL self_loop got pc=%0d cnt=%0d want 147/6", pc_a, cnt_a);
    end
    ctl_clear();
  endtask

  task automatic test_stall();
    Stall = 1; Jump_en = 1; Target = 12'd55; Halt = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (pc_a !== 12'd147 || cnt_a !== 16'd6 || done_a !== 1'b0) begin
        bad++; $display("FAIL stall%0d got pc=%0d cnt=%0d d=%b want 147/6/0", k, pc_a, cnt_a, done_a);
      end
    end
    Stall = 0; Halt = 0;
    tick();
    total++;
    if (pc_a !== 12'd55 || cnt_a !== 16'd7) begin
      bad++; $display("FAIL stall_release got pc=%0d cnt=%0d want 55/7", pc_a, cnt_a);
    end
    ctl_clear();
  endtask

  task automatic test_halt();
    Start = 1; Start_addr = 12'd140;
    tick();
    Start = 0;
    repeat (5) tick();
    Halt = 1;
    tick();
    Halt = 0;
    total++;
    if (done_a !== 1'b1 || vld_a !== 1'b0 || pc_a !== 12'd145 || cnt_a !== 16'd6) begin
      bad++;
      $display("FAIL halt got d=%b v=%b pc=%0d cnt=%0d want 1/0/145/6", done_a, vld_a, pc_a, cnt_a);
    end
    for (int k = 0; k < 10; k++) begin
      Stall = 1'($urandom); Jump_en = 1'($urandom); Branch_en = 1'($urandom);
      Cond = 1'($urandom); Halt = 1'($urandom); Target = 12'($urandom_range(0, 20));
      tick();
      total++;
      if (done_a !== 1'b1 || vld_a !== 1'b0 || pc_a !== 12'd145 || cnt_a !== 16'd6) begin
        bad++;
        $display("FAIL halt_hold%0d got d=%b v=%b pc=%0d cnt=%0d", k, done_a, vld_a, pc_a, cnt_a);
      end
    end
    ctl_clear();
    Start = 1; Start_addr = 12'd0;
    tick();
    Start = 0;
    total++;
    if (vld_a !== 1'b1 || done_a !== 1'b0 || pc_a !== 12'd0 || cnt_a !== 16'd0) begin
      bad++;
      $display("FAIL halt_restart got v=%b d=%b pc=%0d cnt=%0d want 1/0/0/0", vld_a, done_a, pc_a, cnt_a);
    end
  endtask

  task automatic test_end_addr();
    Start = 1; Start_addr = 12'd18;
    tick();
    Start = 0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (int'(pc_b) != 18 + k || vld_b !== 1'b1) begin
        bad++; $display("FAIL end_walk%0d got pc=%0d v=%b want %0d/1", k, pc_b, vld_b, 18 + k);
      end
      tick();
    end
    total++;
    if (done_b !== 1'b1 || vld_b !== 1'b0 || pc_b !== 12'd20 || cnt_b !== 16'd3) begin
      bad++;
      $display("FAIL end_halt got d=%b v=%b pc=%0d cnt=%0d want 1/0/20/3", done_b, vld_b, pc_b, cnt_b);
    end
    total++;
    if (pc_a !== 12'd21 || vld_a !== 1'b1) begin
      bad++; $display("FAIL end_default_runs got pc=%0d v=%b want 21/1", pc_a, vld_a);
    end
    Start = 1; Start_addr = 12'd4094;
    tick();
    Start = 0;
    tick(); tick();
    total++;
    if (done_a !== 1'b1 || pc_a !== 12'd4095 || cnt_a !== 16'd2) begin
      bad++; $display("FAIL end_4095 got d=%b pc=%0d cnt=%0d want 1/4095/2", done_a, pc_a, cnt_a);
    end
  endtask

  task automatic test_saturation();
    Start = 1; Start_addr = 12'd100;
    tick();
    Start = 0;
    repeat (20) tick();
    total++;
    if (cnt_c !== 4'd15 || pc_c !== 12'd120 || vld_c !== 1'b1) begin
      bad++; $display("FAIL sat_cnt got cnt=%0d pc=%0d want 15/120", cnt_c, pc_c);
    end
    total++;
    if (cnt_a !== 16'd20) begin bad++; $display("FAIL sat_wide got cnt=%0d want 20", cnt_a); end
  endtask

  task automatic test_back_to_back();
    Start = 1; Start_addr = 12'd7;
    tick();
    Start_addr = 12'd300;
    tick();
    Start = 0;
    total++;
    if (pc_a !== 12'd300 || cnt_a !== 16'd0) begin
      bad++; $display("FAIL restart got pc=%0d cnt=%0d want 300/0", pc_a, cnt_a);
    end
    tick();
    Start = 1; Start_addr = 12'd50; Stall = 1; Halt = 1;
    tick();
    ctl_clear();
    total++;
    if (pc_a !== 12'd50 || cnt_a !== 16'd0 || vld_a !== 1'b1) begin
      bad++; $display("FAIL start_prio got pc=%0d cnt=%0d want 50/0", pc_a, cnt_a);
    end
    Jump_en = 1; Branch_en = 1; Cond = 0; Target = 12'd77;
    tick();
    ctl_clear();
    total++;
    if (pc_a !== 12'd77 || cnt_a !== 16'd1) begin
      bad++; $display("FAIL jump_and_branch got pc=%0d cnt=%0d want 77/1", pc_a, cnt_a);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      Start      = ($urandom_range(0, 15) == 0);
      Start_addr = 12'($urandom);
      Stall      = ($urandom_range(0, 4) == 0);
      Jump_en    = ($urandom_range(0, 5) == 0);
      Branch_en  = ($urandom_range(0, 3) == 0);
      Cond       = 1'($urandom);
      Halt       = ($urandom_range(0, 29) == 0);
      Target     = 12'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        Reset = 1'b0;
        model_reset();
        #1 Reset = 1'b1;
      end else begin
        tick();
      end
      for (int i = 0; i < 3; i++) begin
        total++;
        if (pc_of(i) != m_pc[i] || cnt_of(i) != m_cnt[i] ||
            vld_of(i) !== m_run[i] || done_of(i) !== m_halt[i]) begin
          bad++;
          $display("FAIL rand[%0d] cyc %0d got pc=%0d cnt=%0d v=%b d=%b want %0d/%0d/%b/%b",
                   i, cyc, pc_of(i), cnt_of(i), vld_of(i), done_of(i),
                   m_pc[i], m_cnt[i], m_run[i], m_halt[i]);
        end
      end
    end
    ctl_clear();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_jump_branch();
    test_stall();
    test_halt();
    test_end_addr();
    test_saturation();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Fetch-stage program counter that consumes the 12-bit absolute jump target produced by the jump lookup table.
- Drives the instruction-memory address and sequences program execution through three states: IDLE, RUN and HALT.
- Handles sequential advance, unconditional and conditional jumps, stall and halt.
- Reports Done to the testbench and keeps a saturating count of executed instructions for performance checks.

Parameters:
PC_W, 12, width of program counter and jump target
END_ADDR, 4095, last legal instruction address; advancing past it halts
CNT_W, 16, width of executed-instruction counter

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-low reset
Start  input  1  one-cycle pulse; begins execution at Start_addr
Start_addr  input  PC_W  first instruction address, sampled with Start
Stall  input  1  hold PC this cycle (RUN only)
Jump_en  input  1  unconditional jump to Target
Branch_en  input  1  conditional jump to Target if Cond=1
Cond  input  1  branch condition flag from ALU
Target  input  PC_W  absolute target from jump lookup table
Halt  input  1  decoded halt instruction at current PC
Prog_ctr  output  PC_W  instruction-memory address
Valid  output  1  Prog_ctr holds an instruction to execute (state RUN)
Done  output  1  high while in HALT
Instr_cnt  output  CNT_W  instructions retired since last Start, saturating

Behaviour:
- Reset low, asynchronous: state=IDLE, Prog_ctr=0, Valid=0, Done=0, Instr_cnt=0. Deassertion takes effect at the next Clk edge. Reset mid-RUN aborts immediately with no partial update.
- Outputs are registered. Valid = (state==RUN). Done = (state==HALT).
- IDLE: Prog_ctr holds. On Start: Prog_ctr<=Start_addr, Instr_cnt<=0, go to RUN. All other inputs are ignored.
- RUN, per cycle, in priority order:
  1. Start: restart exactly as from IDLE.
  2. Stall: hold Prog_ctr and Instr_cnt. Jump, Branch and Halt are ignored this cycle; the decoder must re-present them.
  3. Halt: go to HALT, Prog_ctr holds, Instr_cnt+1.
  4. Jump_en, or Branch_en&&Cond: Prog_ctr<=Target, Instr_cnt+1.
  5. Otherwise, Prog_ctr==END_ADDR: go to HALT, Prog_ctr holds, Instr_cnt+1. No wrap to 0.
  6. Otherwise: Prog_ctr<=Prog_ctr+1, Instr_cnt+1.
- Jump_en and Branch_en together: treated as a jump; Cond is ignored.
- Branch_en with Cond=0: sequential advance (rule 5/6).
- Target beyond END_ADDR: loaded as given; the next sequential step halts via rule 5 only when equal, so the decoder must not emit such targets. Assertion in bench.
- A taken jump to the current Prog_ctr (self-loop) is legal and executes every cycle.
- Instr_cnt saturates at 2^CNT_W-1 and never wraps.
- HALT: all outputs hold. Start restarts as from IDLE. Nothing else leaves HALT except Reset.
- Latency: Target and Start_addr are visible on Prog_ctr one cycle after the control inputs are sampled.

Test Plan:
- Reset low mid-RUN at Prog_ctr=37 -> same cycle Prog_ctr=0, Valid=0, Done=0, Instr_cnt=0; held until Start.
- Start with Start_addr=5, then 3 idle-control cycles -> Prog_ctr 5,6,7,8; Instr_cnt=3; Valid=1.
- At PC=10: Jump_en=1, Target=88 -> PC=88. Branch_en=1, Cond=0, Target=147 -> PC=89. Branch_en=1, Cond=1, Target=147 -> PC=147.
- Stall=1 for 2 cycles together with Jump_en, Target=55 -> PC and Instr_cnt frozen, no jump. After Stall drops with Jump_en still high -> PC=55.
- Halt at PC=145 -> next cycle Done=1, Valid=0, PC=145, all outputs held for 10 cycles. Start with Start_addr=0 -> RUN, PC=0, Instr_cnt=0.
- END_ADDR=20 override, run from 18 -> PC 18,19,20, then Done=1 with PC=20. Separately, CNT_W=4 over 20 cycles -> Instr_cnt sticks at 15.
